// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-entry pipeline skid register. The main register drives
//               out_data and a skid register absorbs one extra beat, so
//               in_ready can be a flop with no path from out_ready. A flush
//               empties the stage and counts discarded entries in a
//               saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int              DW        = 64,
    parameter logic [DW-1:0]   NOP_VALUE = '0,
    parameter int              CW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occupancy,
    output logic [CW-1:0] flush_drops
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [CW+1:0] c_sat = {2'b00, {CW{1'b1}}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic [DW-1:0] w_main_nxt;
    logic [DW-1:0] w_skid_nxt;
    logic [CW-1:0] r_drops;
    logic [CW-1:0] w_drops_nxt;
    logic          r_in_ready;
    logic          w_in_fire;
    logic          w_out_fire;
    logic [CW+1:0] w_drop_sum;

    assign out_valid   = (r_state != S_EMPTY);
    assign in_ready    = r_in_ready;
    assign out_data    = r_main;
    assign occupancy   = r_state;
    assign flush_drops = r_drops;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Entries lost to a flush: everything held plus the incoming beat, less
    // the head if it is being delivered on the same edge.
    assign w_drop_sum = {2'b00, r_drops} + {{CW{1'b0}}, r_state}
                      + {{(CW+1){1'b0}}, w_in_fire}
                      - {{(CW+1){1'b0}}, w_out_fire};

    // Next-state, datapath and drop-counter selection.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        w_drops_nxt = r_drops;
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = NOP_VALUE;
            w_skid_nxt  = NOP_VALUE;
            w_drops_nxt = (w_drop_sum > c_sat) ? c_sat[CW-1:0] : w_drop_sum[CW-1:0];
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_state_nxt = S_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                        w_main_nxt  = NOP_VALUE;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so only the output side can move.
                    if (w_out_fire) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = NOP_VALUE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = NOP_VALUE;
                    w_skid_nxt  = NOP_VALUE;
                end
            endcase
        end
    end

    // State, payload and counter registers; in_ready follows the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_main     <= NOP_VALUE;
            r_skid     <= NOP_VALUE;
            r_drops    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_drops    <= w_drops_nxt;
            r_in_ready <= (w_state_nxt != S_FULL);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Self-checking bench for pipe_skid_reg. A queue-based model
//               of a two-deep FIFO with flush accounting predicts every
//               output; directed sequences are followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int            DW        = 16;
    localparam int            CW        = 2;
    localparam logic [DW-1:0] NOP_VALUE = '0;
    localparam int            c_max     = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] flush_drops;

    int n_tests;
    int n_fail;

    // Reference model: list of held payloads plus the drop total.
    logic [DW-1:0] m_q[$];
    int            m_drops;

    pipe_skid_reg #(
        .DW        (DW),
        .NOP_VALUE (NOP_VALUE),
        .CW        (CW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .flush_drops (flush_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every DUT output with what the model says is held right now.
    task automatic check_outputs();
        int sz;
        sz = m_q.size();
        check("occupancy",   32'(occupancy),   32'(sz));
        check("out_valid",   32'(out_valid),   32'(sz > 0));
        check("out_data",    32'(out_data),    (sz > 0) ? 32'(m_q[0]) : 32'(NOP_VALUE));
        check("in_ready",    32'(in_ready),    32'(sz < 2));
        check("flush_drops", 32'(flush_drops), 32'(m_drops));
    endtask

    // Apply one cycle of inputs: check pre-edge outputs, clock, update model.
    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [DW-1:0] id, input logic ordy);
        bit in_fire;
        bit out_fire;
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        check_outputs();
        in_fire  = iv && (m_q.size() < 2);
        out_fire = ordy && (m_q.size() > 0);
        @(posedge clk);
        #1;
        if (r) begin
            m_q.delete();
            m_drops = 0;
        end else if (f) begin
            m_drops = m_drops + m_q.size() + int'(in_fire) - int'(out_fire);
            if (m_drops > c_max) m_drops = c_max;
            m_q.delete();
        end else begin
            if (out_fire) void'(m_q.pop_front());
            if (in_fire)  m_q.push_back(id);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_drops   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 0, 0, '0, 0);

        // Streaming: one beat per cycle, each visible one cycle after entry.
        for (int i = 1; i <= 5; i++) drive(0, 0, 1, DW'(i), 1);
        drive(0, 0, 0, '0, 1);

        // Backpressure: two beats stack up, a third is held off, then drain.
        drive(0, 0, 1, 16'h000A, 0);
        drive(0, 0, 1, 16'h000B, 0);
        drive(0, 0, 1, 16'h000C, 0);
        drive(0, 0, 1, 16'h000C, 1);
        drive(0, 0, 1, 16'h000C, 1);
        drive(0, 0, 0, '0, 1);
        drive(0, 0, 0, '0, 1);
        drive(0, 0, 0, '0, 1);

        // Flush of a full stage with nothing incoming.
        drive(1, 0, 0, '0, 0);
        drive(0, 0, 1, 16'h0011, 0);
        drive(0, 0, 1, 16'h0022, 0);
        drive(0, 1, 0, '0, 0);
        drive(0, 0, 0, '0, 0);

        // Flush in ONE with simultaneous in_fire and out_fire.
        drive(1, 0, 0, '0, 0);
        drive(0, 0, 1, 16'h0033, 0);
        drive(0, 1, 1, 16'h0044, 1);
        drive(0, 0, 0, '0, 0);

        // Saturation: repeated flushes of a full stage.
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, DW'(16'h0100 + k), 0);
            drive(0, 0, 1, DW'(16'h0200 + k), 0);
            drive(0, 1, 0, '0, 0);
        end
        drive(0, 0, 0, '0, 0);

        // Reset and flush together while full.
        drive(0, 0, 1, 16'h0055, 0);
        drive(0, 0, 1, 16'h0066, 0);
        drive(1, 1, 0, '0, 0);
        drive(0, 0, 0, '0, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 6),
                  ($urandom_range(0, 99) < 70),
                  DW'($urandom),
                  ($urandom_range(0, 99) < 60));
        end
        drive(0, 0, 0, '0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is synchronous and active-high, rst.
REQ-002 Parameter DW, default 64, SHALL set the payload width (instruction plus PC+4).
REQ-003 Parameter NOP_VALUE, default all-zero DW bits, SHALL set the payload presented while the stage holds no valid entry.
REQ-004 Parameter CW, default 8, SHALL set the width of the flush-drop counter.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held entries this edge
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept; registered
- in_data  in  DW  upstream payload
- out_valid  out  1  downstream payload valid
- out_ready  in  1  downstream accepts
- out_data  out  DW  downstream payload
- occupancy  out  2  entries held, 0..2
- flush_drops  out  CW  saturating count of entries discarded by flush

Function
REQ-006 Storage SHALL be a main register (drives out_data) plus one skid register; states: EMPTY (occupancy 0), ONE (1), FULL (2).
REQ-007 in_fire = in_valid & in_ready and out_fire = out_valid & out_ready, each sampled at the rising edge of clk.
REQ-008 in_ready SHALL be a flop output equal to 1 in EMPTY and ONE and 0 in FULL, with no combinational path from out_ready.
REQ-009 out_valid SHALL be 1 exactly in ONE and FULL; out_data SHALL equal NOP_VALUE whenever out_valid = 0.
REQ-010 EMPTY: in_fire -> ONE with main <= in_data; otherwise stay.
REQ-011 ONE: in_fire & out_fire -> ONE with main <= in_data; in_fire & !out_fire -> FULL with skid <= in_data; out_fire & !in_fire -> EMPTY; neither -> hold.
REQ-012 FULL: out_fire -> ONE with main <= skid; otherwise hold. in_valid SHALL be ignored because in_ready = 0.
REQ-013 Ordering SHALL be strict FIFO; no payload is duplicated, reordered or lost except by flush or rst.
REQ-014 Throughput SHALL be one transfer per cycle when out_ready = 1 continuously; latency from in_fire to out_valid SHALL be 1 cycle.
REQ-015 flush = 1 (rst = 0) SHALL force EMPTY at the edge, set out_data to NOP_VALUE and in_ready to 1, and discard any same-cycle in_fire payload.
REQ-016 The handshake for an in_fire during flush SHALL complete (upstream sees acceptance), and the payload SHALL be dropped.
REQ-017 On flush, flush_drops SHALL add the pre-flush occupancy plus 1 if in_fire, saturating at 2^CW-1.
REQ-018 An out_fire coinciding with flush SHALL count as delivered; the delivered entry SHALL NOT be counted in flush_drops.
REQ-019 With flush = 0, out_valid, out_data and the held payloads SHALL be stable while out_ready = 0.

Reset
REQ-020 rst SHALL take priority over flush and all handshakes.
REQ-021 On rst the block SHALL set occupancy 0, out_valid 0, out_data NOP_VALUE, in_ready 1 and flush_drops 0, and clear the skid register to NOP_VALUE.
REQ-022 rst asserted mid-transfer SHALL discard held entries without incrementing flush_drops.

Verification
REQ-023 Streaming: rst then in_valid=1 with payloads 0x1..0x5 on consecutive cycles and out_ready=1 -> out_data 0x1..0x5 one cycle later each; occupancy stays 1; in_ready stays 1.
REQ-024 Backpressure: accept 0xA, then 0xB with out_ready=0 -> occupancy 2 and in_ready=0; in_valid with 0xC is held off; out_ready=1 -> outputs 0xA, 0xB, 0xC in order, no loss.
REQ-025 Flush while FULL with in_fire=0 -> next cycle occupancy 0, out_valid 0, out_data 0, flush_drops +2.
REQ-026 Flush in ONE with in_fire and out_fire in the same cycle -> flush_drops +1 (incoming only); the head is delivered and EMPTY follows.
REQ-027 Saturation: CW=2, three flushes of FULL -> flush_drops 3, not wrapping.
REQ-028 rst and flush together while FULL -> all outputs at reset values; flush_drops 0.
